ram_loader: RTL and testbench

Initiator-side controller for the synchronous single-port RAM. It fills a RAM region from a byte stream for program/data load, and reads a region back out as a stream for dump/verify. It sits between the host/debug link and the RAM's addr/din/we/dout pins, and absorbs the RAM's one-clock read latency.

---
 rtl/ram_loader_pkg.sv | 22 ++
 rtl/ram_loader.sv | 143 ++++++++++++++
 tb/tb_ram_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - shared state encoding and start-priority constant for ram_loader
`ifndef RAM_LOADER_DEFS_SV
`define RAM_LOADER_DEFS_SV

package ram_loader_pkg;

  typedef enum logic [2:0] {
    st_idle    = 3'd0,
    st_load    = 3'd1,
    st_lflush  = 3'd2,
    st_rd_wait = 3'd3,
    st_rd_cap  = 3'd4,
    st_rd_out  = 3'd5,
    st_done    = 3'd6
  } state_e;

  // When start_load and start_dump arrive together, this picks the load.
  localparam logic start_load_first = 1'b1;

endpackage

`endif

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - fills a RAM region from a byte stream and dumps a region back out as a stream
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_load,
  input  logic                  start_dump,
  input  logic [addr_width-1:0] base,
  input  logic [addr_width:0]   len,
  input  logic                  s_valid,
  input  logic [data_width-1:0] s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [data_width-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  output logic                  ram_we,
  input  logic [data_width-1:0] ram_dout
);

  localparam logic [addr_width-1:0] ptr_one = addr_width'(1);
  localparam logic [addr_width:0]   cnt_one = (addr_width + 1)'(1);

  state_e                  state_q, state_d;
  logic [addr_width-1:0]   ptr_q, ptr_d;
  logic [addr_width:0]     count_q, count_d;
  logic [addr_width-1:0]   ram_addr_q, ram_addr_d;
  logic [data_width-1:0]   ram_din_q, ram_din_d;
  logic                    ram_we_q, ram_we_d;
  logic                    m_valid_q, m_valid_d;
  logic [data_width-1:0]   m_data_q, m_data_d;

  logic acc_load, acc_dump, len_zero, last_word, out_fire;

  assign acc_load  = (state_q == st_idle) && start_load && (start_load_first || !start_dump);
  assign acc_dump  = (state_q == st_idle) && start_dump && !acc_load;
  assign len_zero  = (len == '0);
  assign last_word = (count_q == cnt_one);
  assign out_fire  = m_valid_q && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= st_idle;
      ptr_q      <= '0;
      count_q    <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle: begin
        if (acc_load || acc_dump) begin
          if (len_zero)      state_d = st_done;
          else if (acc_load) state_d = st_load;
          else               state_d = st_rd_wait;
        end
      end
      st_load:    if (s_valid && last_word) state_d = st_lflush;
      st_lflush:  state_d = st_done;
      st_rd_wait: state_d = st_rd_cap;
      st_rd_cap:  state_d = st_rd_out;
      st_rd_out:  if (out_fire) state_d = last_word ? st_done : st_rd_wait;
      st_done:    state_d = st_idle;
      default:    state_d = st_idle;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    count_d    = count_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    case (state_q)
      st_idle: begin
        if (acc_load || acc_dump) begin
          ptr_d   = base;
          count_d = len;
          if (acc_dump && !len_zero) ram_addr_d = base;
        end
      end
      st_load: begin
        if (s_valid) begin
          ram_addr_d = ptr_q;
          ram_din_d  = s_data;
          ram_we_d   = 1'b1;
          ptr_d      = ptr_q + ptr_one;
          count_d    = count_q - cnt_one;
        end
      end
      st_rd_cap: begin
        // RAM dout now reflects the address sampled on the RD_WAIT edge.
        m_data_d  = ram_dout;
        m_valid_d = 1'b1;
      end
      st_rd_out: begin
        if (out_fire) begin
          m_valid_d = 1'b0;
          ptr_d     = ptr_q + ptr_one;
          count_d   = count_q - cnt_one;
          if (!last_word) ram_addr_d = ptr_q + ptr_one;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    s_ready  = (state_q == st_load);
    busy     = (state_q != st_idle);
    done     = (state_q == st_done);
    ram_addr = ram_addr_q;
    ram_din  = ram_din_q;
    ram_we   = ram_we_q;
    m_valid  = m_valid_q;
    m_data   = m_data_q;
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - directed and randomized checks of ram_loader against a reference memory image
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_load, start_dump;
  logic [7:0] base;
  logic [8:0] len;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       busy, done;
  logic [7:0] ram_addr, ram_din, ram_dout;
  logic       ram_we;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;

  ram_loader #(.addr_width(8), .data_width(8)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .start_dump(start_dump),
    .base(base), .len(len), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_image(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic do_load(input logic [7:0] b, input logic [8:0] n, input logic [7:0] data[$],
                         input bit gaps, input bit both);
    int acc = 0;
    int cyc = 0;
    int d0  = done_cnt;
    base = b; len = n; start_load = 1'b1; start_dump = both;
    step();
    start_load = 1'b0; start_dump = 1'b0;
    check("load_s_ready", s_ready, 1);
    check("load_busy", busy, 1);
    while (acc < n && cyc < 4000) begin
      s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = data[acc];
      step();
      cyc++;
      check("load_we", ram_we, s_valid);
      if (s_valid) begin
        check("load_din", ram_din, data[acc]);
        check("load_addr", ram_addr, (int'(b) + acc) % 256);
        ref_mem[(int'(b) + acc) % 256] = data[acc];
        acc++;
      end
    end
    check("load_beats", acc, n);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    check("load_ready_after_last", s_ready, 0);
    step();
    s_valid = 1'b0;
    check("load_done", done, 1);
    check("load_we_off", ram_we, 0);
    step();
    check("load_done_once", done_cnt - d0, 1);
    check("load_idle", busy, 0);
  endtask

  task automatic do_dump(input logic [7:0] b, input logic [8:0] n, input int stall_idx,
                         input bit rnd_ready, input bit poke);
    int idx = 0;
    int cyc = 0;
    int first = -1;
    int stall_left = 5;
    int limit = 40 * int'(n) + 20;
    int d0 = done_cnt;
    bit was_stalled = 0;
    logic [7:0] held_data = '0;
    logic [7:0] held_addr = '0;
    base = b; len = n; m_ready = 1'b1; start_dump = 1'b1;
    step();
    start_dump = 1'b0;
    while (idx < n && cyc < limit) begin
      if (poke && cyc == 1) begin
        start_load = 1'b1; base = ~b; len = 9'd1;
      end else begin
        start_load = 1'b0;
      end
      if (was_stalled) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, held_data);
        check("stall_addr", ram_addr, held_addr);
      end
      if (cyc == 1) check("dump_s_ready", s_ready, 0);
      if (m_valid) begin
        if (first < 0) first = cyc;
        if (idx == stall_idx && stall_left > 0) begin
          m_ready = 1'b0;
          stall_left--;
          was_stalled = 1;
          held_data = m_data;
          held_addr = ram_addr;
        end else begin
          m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          was_stalled = 0;
          if (m_ready) begin
            check("dump_data", m_data, ref_mem[(int'(b) + idx) % 256]);
            idx++;
          end
        end
      end else begin
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        was_stalled = 0;
      end
      step();
      cyc++;
    end
    start_load = 1'b0;
    m_ready = 1'b1;
    check("dump_words", idx, n);
    check("dump_first_valid", first, 2);
    check("dump_done", done, 1);
    check("dump_we_quiet", ram_we, 0);
    step();
    check("dump_done_once", done_cnt - d0, 1);
    check("dump_idle", busy, 0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] rb;
    logic [8:0] rn;
    int d0;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    rst = 1'b1; start_load = 0; start_dump = 0; base = 0; len = 0;
    s_valid = 0; s_data = 0; m_ready = 1;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", ram_we, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_m_data", m_data, 0);
    rst = 1'b0;
    step();

    q = '{8'hAA, 8'hBB, 8'hCC};
    do_load(8'h10, 9'd3, q, 0, 0);
    check("ram10", mem[8'h10], 8'hAA);
    check("ram11", mem[8'h11], 8'hBB);
    check("ram12", mem[8'h12], 8'hCC);
    check("ram13_untouched", mem[8'h13], ref_mem[8'h13]);

    do_dump(8'h10, 9'd3, -1, 0, 0);
    do_dump(8'h10, 9'd3, 1, 0, 0);

    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_load(8'hFE, 9'd4, q, 0, 0);
    check("wrap_fe", mem[8'hFE], 8'h01);
    check("wrap_ff", mem[8'hFF], 8'h02);
    check("wrap_00", mem[8'h00], 8'h03);
    check("wrap_01", mem[8'h01], 8'h04);
    do_dump(8'hFE, 9'd4, -1, 0, 0);

    d0 = done_cnt;
    base = 8'h40; len = 9'd0; start_load = 1; start_dump = 1;
    step();
    start_load = 0; start_dump = 0;
    check("len0_done", done, 1);
    check("len0_s_ready", s_ready, 0);
    check("len0_we", ram_we, 0);
    check("len0_m_valid", m_valid, 0);
    step();
    check("len0_idle", busy, 0);
    check("len0_done_once", done_cnt - d0, 1);
    check_image("len0_image");

    q = '{8'h77, 8'h88};
    do_load(8'h50, 9'd2, q, 0, 1);
    check_image("prio_image");

    base = 8'h80; len = 9'd4; start_load = 1;
    step();
    start_load = 0;
    s_valid = 1; s_data = 8'h11;
    step();
    ref_mem[8'h80] = 8'h11;
    s_data = 8'h22;
    step();
    ref_mem[8'h81] = 8'h22;
    s_data = 8'h33;
    rst = 1;
    step();
    rst = 0; s_valid = 0;
    check("abort_busy", busy, 0);
    check("abort_we", ram_we, 0);
    check("abort_s_ready", s_ready, 0);
    step();
    check_image("abort_image");
    do_dump(8'h80, 9'd4, -1, 0, 0);

    for (int t = 0; t < 6; t++) begin
      rb = 8'($urandom);
      rn = 9'($urandom_range(1, 9));
      q.delete();
      for (int k = 0; k < int'(rn); k++) q.push_back(8'($urandom));
      do_load(rb, rn, q, 1, 0);
      do_dump(rb, rn, int'($urandom_range(0, int'(rn) - 1)), 1, t[0]);
    end
    check_image("random_image");

    rb = 8'($urandom);
    q.delete();
    for (int k = 0; k < 256; k++) q.push_back(8'($urandom));
    do_load(rb, 9'd256, q, 1, 0);
    check_image("full_image");
    do_dump(rb, 9'd256, -1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
